// File: rtl/cpu_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define CPU_DIVIDER_FAST_PATH_EN to resolve divide-by-zero and signed overflow without the CALC phase.
module cpu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] rem_reg, quo_reg, divisor_reg, result_reg, special_reg;
   logic             special_hit_reg, neg_quo_reg, neg_rem_reg, want_rem_reg;
   logic [CW-1:0]    count_reg;

   logic             load_ops, load_result;
   logic [WIDTH-1:0] result_next;

   // Operand decode at acceptance
   logic             is_signed, want_rem, a_neg, b_neg, div_zero, ovf, special_hit;
   logic [WIDTH-1:0] a_abs, b_abs, special_val;

   always_comb begin
      is_signed   = ~op[0];
      want_rem    = op[1];
      a_neg       = is_signed & operand_a[WIDTH-1];
      b_neg       = is_signed & operand_b[WIDTH-1];
      a_abs       = a_neg ? (~operand_a + 1'b1) : operand_a;
      b_abs       = b_neg ? (~operand_b + 1'b1) : operand_b;
      div_zero    = (operand_b == '0);
      ovf         = is_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b);
      special_hit = div_zero | ovf;
      if (div_zero) begin
         special_val = want_rem ? operand_a : '1;
      end else begin
         special_val = want_rem ? '0 : operand_a;
      end
   end

   // One restoring step; a set MSB in the shifted value already guarantees no borrow
   logic [WIDTH:0]   shifted, diff;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix, calc_val;

   always_comb begin
      shifted   = {rem_reg, quo_reg[WIDTH-1]};
      diff      = shifted - {1'b0, divisor_reg};
      no_borrow = shifted[WIDTH] | ~diff[WIDTH];
      rem_step  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_step  = {quo_reg[WIDTH-2:0], no_borrow};
      quo_fix   = neg_quo_reg ? (~quo_step + 1'b1) : quo_step;
      rem_fix   = neg_rem_reg ? (~rem_step + 1'b1) : rem_step;
      if (special_hit_reg) begin
         calc_val = special_reg;
      end else begin
         calc_val = want_rem_reg ? rem_fix : quo_fix;
      end
   end

   // result_reg is written on the edge entering DONE so it is valid alongside done
   always_comb begin
      state_next  = state_reg;
      load_ops    = 1'b0;
      load_result = 1'b0;
      result_next = calc_val;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  load_ops   = 1'b1;
                  state_next = S_CALC;
`ifdef CPU_DIVIDER_FAST_PATH_EN
                  if (special_hit) begin
                     state_next  = S_DONE;
                     load_result = 1'b1;
                     result_next = special_val;
                  end
`endif
               end
            end
            S_CALC: begin
               if (count_reg == CW'(1)) begin
                  state_next  = S_DONE;
                  load_result = 1'b1;
               end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         rem_reg         <= '0;
         quo_reg         <= '0;
         divisor_reg     <= '0;
         result_reg      <= '0;
         special_reg     <= '0;
         special_hit_reg <= 1'b0;
         neg_quo_reg     <= 1'b0;
         neg_rem_reg     <= 1'b0;
         want_rem_reg    <= 1'b0;
         count_reg       <= '0;
      end else begin
         state_reg <= state_next;
         if (load_ops) begin
            rem_reg         <= '0;
            quo_reg         <= a_abs;
            divisor_reg     <= b_abs;
            special_reg     <= special_val;
            special_hit_reg <= special_hit;
            neg_quo_reg     <= a_neg ^ b_neg;
            neg_rem_reg     <= a_neg;
            want_rem_reg    <= want_rem;
            count_reg       <= CW'(WIDTH);
         end else if (state_reg == S_CALC) begin
            rem_reg   <= rem_step;
            quo_reg   <= quo_step;
            count_reg <= count_reg - 1'b1;
         end
         if (load_result) begin
            result_reg <= result_next;
         end
      end
   end

   assign busy   = (state_reg != S_IDLE);
   assign done   = (state_reg == S_DONE);
   assign result = result_reg;

endmodule

// File: tb/tb_cpu_divider.sv
// Directed-vector bench for cpu_divider (WIDTH=32): results, latency, abort, ignored start, reset.
module tb_cpu_divider;

   localparam int W = 32;
`ifdef CPU_DIVIDER_FAST_PATH_EN
   localparam int LAT_SPECIAL = 1;
`else
   localparam int LAT_SPECIAL = W + 1;
`endif
   localparam int LAT = W + 1;

   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [1:0]   op;
   logic [W-1:0] operand_a, operand_b, result;
   logic         busy, done;

   int n_vec = 0;
   int n_bad = 0;

   cpu_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; leaves the bench #1 after an edge with the DUT idle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int cyc;
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_res"}, result, exp);
      $display("op %-14s a=0x%08h b=0x%08h result=0x%08h cycle=%0d", tag, a, b, result, cyc);
      @(posedge clk); #1;
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int cyc;
      int n_done;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op = DIVU; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {busy, done, result[29:0]}, 32'd0);
      check("reset_res", result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14, LAT);
      run_op("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2, LAT);
      run_op("div_m7_2",    DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
      run_op("rem_m7_2",    REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
      run_op("div_7_m2",    DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
      run_op("rem_7_m2",    REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT);
      run_op("divu_max_1",  DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT);
      run_op("remu_max_16", REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, LAT);
      run_op("divu_min_m1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);
      run_op("remu_min_m1", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT);
      run_op("div_5_0",     DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
      run_op("remu_5_0",    REMU, 32'd5, 32'd0, 32'd5, LAT_SPECIAL);
      run_op("rem_m5_0",    REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPECIAL);
      run_op("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
      run_op("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPECIAL);
      run_op("divu_1000_3", DIVU, 32'd1000, 32'd3, 32'd333, LAT);

      // Abort in cycle 10: no done, busy low in cycle 11, result held
      op = DIVU; operand_a = 32'd77; operand_b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; n_done = 0;
      while (cyc < 10) begin
         n_done += int'(done);
         @(posedge clk); #1;
         cyc++;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_done_seen", n_done, 0);
      check("abort_state", {30'd0, busy, done}, 32'd0);
      check("abort_res_held", result, 32'd333);
      $display("op %-14s aborted in cycle 10, result=0x%08h", "abort", result);
      run_op("abort_restart", DIVU, 32'd1000, 32'd7, 32'd142, LAT);

      // Start during CALC is ignored
      op = DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc == 5) begin
            start = 1'b1; op = REMU; operand_a = 32'd9; operand_b = 32'd4;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check("ignore_lat", cyc, LAT);
      check("ignore_res", result, 32'd14);
      $display("op %-14s result=0x%08h cycle=%0d", "ignore_start", result, cyc);
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         n_done += int'(done);
      end
      check("ignore_no_2nd_done", n_done, 0);
      check("ignore_res_held", result, 32'd14);

      // Reset mid-CALC clears everything
      op = DIVU; operand_a = 32'd50; operand_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_busy_done", {30'd0, busy, done}, 32'd0);
      check("rst_res", result, 32'd0);
      $display("op %-14s reset mid-CALC, result=0x%08h", "reset", result);
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         n_done += int'(done);
      end
      check("rst_no_done", n_done, 0);
      run_op("after_rst", REMU, 32'd50, 32'd3, 32'd2, LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
